// File: rtl/seq_alu_reg.sv
// Registered ALU with Start/Busy/Done handshake, shift-add multiply and accumulate mode.
// Optional Zero/Carry flag outputs are enabled by defining SEQ_ALU_FLAGS_EN.
module seq_alu_reg #(
    parameter int WIDTH = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [2:0]         Opcode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               UseReg,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Result
`ifdef SEQ_ALU_FLAGS_EN
    ,
    output logic               Zero,
    output logic               Carry
`endif
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_NORNAND = 3'b010,
        OP_ANYSET  = 3'b011,
        OP_XORXNOR = 3'b100,
        OP_MUL     = 3'b101,
        OP_SHL     = 3'b110,
        OP_HOLD    = 3'b111
    } op_t;

    state_t          state;
    state_t          state_nx;
    op_t             op;
    logic            accept;
    logic            mul_last;
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]  sum;
    logic [WIDTH:0]  diff;
    logic [RW-1:0]   alu_res;
    logic [RW-1:0]   mcand;
    logic [RW-1:0]   acc;
    logic [RW-1:0]   prod;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]   cnt;

    assign op       = op_t'(Opcode);
    assign accept   = Start && (state == S_IDLE);
    assign opb      = UseReg ? Result[WIDTH-1:0] : B;
    assign sum      = {1'b0, A} + {1'b0, opb};
    // Bit WIDTH of the extended difference is the borrow (set when A < B).
    assign diff     = {1'b0, A} - {1'b0, opb};
    assign mul_last = (state == S_MUL) && (cnt == CW'(WIDTH - 1));
    // Final partial product folded in combinationally so the product lands on the last step edge.
    assign prod     = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        alu_res = Result;
        case (op)
            OP_ADD:     alu_res = RW'(sum);
            OP_SUB:     alu_res = RW'(diff);
            OP_NORNAND: alu_res = {~(A | opb), ~(A & opb)};
            OP_ANYSET:  alu_res = {{WIDTH{|(A | opb)}}, {WIDTH{1'b0}}};
            OP_XORXNOR: alu_res = {A ^ opb, ~(A ^ opb)};
            OP_SHL: begin
                if (int'(A) >= RW)
                    alu_res = '0;
                else
                    alu_res = RW'(opb) << A;
            end
            default:    alu_res = Result;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept && (op == OP_MUL)) state_nx = S_MUL;
            S_MUL:   if (mul_last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == S_MUL);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Result <= '0;
            Done   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            Done <= 1'b0;
            if (accept) begin
                case (op)
                    OP_MUL: begin
                        acc    <= '0;
                        mcand  <= RW'(A);
                        mplier <= opb;
                        cnt    <= '0;
                    end
                    OP_HOLD: Done <= 1'b1;
                    default: begin
                        Result <= alu_res;
                        Done   <= 1'b1;
                    end
                endcase
            end else if (state == S_MUL) begin
                if (mplier[0])
                    acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                if (mul_last) begin
                    Result <= prod;
                    Done   <= 1'b1;
                end
            end
        end
    end

`ifdef SEQ_ALU_FLAGS_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Zero  <= 1'b0;
            Carry <= 1'b0;
        end else if (accept && (op != OP_MUL) && (op != OP_HOLD)) begin
            Zero <= (alu_res == '0);
            case (op)
                OP_ADD:  Carry <= sum[WIDTH];
                OP_SUB:  Carry <= diff[WIDTH];
                default: Carry <= 1'b0;
            endcase
        end else if (mul_last) begin
            Zero  <= (prod == '0);
            Carry <= |prod[RW-1:WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_seq_alu_reg.sv
// Scoreboard bench for seq_alu_reg (WIDTH=4): expected results queued at issue,
// popped and compared whenever Done is seen.
module tb_seq_alu_reg;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [2:0] Opcode = 3'b000;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic       UseReg = 1'b0;
    logic       Busy;
    logic       Done;
    logic [7:0] Result;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_res = '0;

    seq_alu_reg #(.WIDTH(4)) dut (
        .Clock (clk),
        .Reset (Reset),
        .Start (Start),
        .Opcode(Opcode),
        .A     (A),
        .B     (B),
        .UseReg(UseReg),
        .Busy  (Busy),
        .Done  (Done),
        .Result(Result)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic [7:0] prev);
        int s;
        case (op)
            3'd0: s = int'(a) + int'(b);
            3'd1: s = (int'(a) - int'(b)) & 31;
            3'd2: s = int'({~(a | b), ~(a & b)});
            3'd3: s = ((a | b) != 4'd0) ? 'hF0 : 0;
            3'd4: s = int'({a ^ b, ~(a ^ b)});
            3'd5: s = int'(a) * int'(b);
            3'd6: s = (a >= 4'd8) ? 0 : ((int'(b) << a) & 'hFF);
            default: s = int'(prev);
        endcase
        return s[7:0];
    endfunction

    // Scoreboard consumer plus the Busy/Done exclusivity check.
    always @(negedge clk) begin
        logic [7:0] e;
        checks++;
        if (Busy && Done) begin
            errors++;
            $display("FAIL busy_done_overlap: Busy=%b Done=%b, required not both 1", Busy, Done);
        end
        if (Done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: Done=1 with Result=%h, required no pulse", Result);
            end else begin
                e = exp_q.pop_front();
                if (Result !== e) begin
                    errors++;
                    $display("FAIL result: got %h, required %h", Result, e);
                end
            end
        end
    end

    task automatic drive_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                            input logic ur, input bit expect_done);
        logic [3:0] bop;
        logic [7:0] e;
        Start  = 1'b1;
        Opcode = op;
        A      = a;
        B      = b;
        UseReg = ur;
        bop    = ur ? model_res[3:0] : b;
        if (expect_done) begin
            e = model(op, a, bop, model_res);
            exp_q.push_back(e);
            model_res = e;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic ur, input bit expect_done);
        @(negedge clk);
        drive_op(op, a, b, ur, expect_done);
        @(negedge clk);
        Start  = 1'b0;
        UseReg = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b1;
        Opcode = 3'b000;
        A = 4'hF;
        B = 4'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (Result !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: Result=%h Busy=%b Done=%b, required 00 0 0", Result, Busy, Done);
            end
        end
        Start = 1'b0;
        Reset = 1'b0;
        model_res = '0;
    endtask

    task automatic test_add_sub();
        issue(3'b000, 4'hF, 4'h1, 1'b0, 1'b1);
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL add_done_high: Done=%b, required 1", Done);
        end
        @(negedge clk);
        checks++;
        if (Done !== 1'b0 || Result !== 8'h10) begin
            errors++;
            $display("FAIL add_done_low: Done=%b Result=%h, required 0 10", Done, Result);
        end
        issue(3'b001, 4'h2, 4'h3, 1'b0, 1'b1);
        issue(3'b001, 4'h9, 4'h3, 1'b0, 1'b1);
        issue(3'b010, 4'hC, 4'hA, 1'b0, 1'b1);
        issue(3'b011, 4'h0, 4'h0, 1'b0, 1'b1);
        issue(3'b011, 4'h0, 4'h4, 1'b0, 1'b1);
        issue(3'b100, 4'h6, 4'hA, 1'b0, 1'b1);
    endtask

    task automatic test_mul();
        logic [7:0] prev;
        int busy_n;
        prev = model_res;
        issue(3'b101, 4'hF, 4'hF, 1'b0, 1'b1);
        busy_n = 0;
        while (Busy === 1'b1 && busy_n < 20) begin
            busy_n++;
            checks++;
            if (Result !== prev) begin
                errors++;
                $display("FAIL mul_result_hold: got %h during MUL, required %h", Result, prev);
            end
            if (busy_n == 2)
                drive_op(3'b000, 4'h1, 4'h1, 1'b0, 1'b0);
            else
                Start = 1'b0;
            @(negedge clk);
        end
        Start = 1'b0;
        checks++;
        if (busy_n != 4 || Done !== 1'b1) begin
            errors++;
            $display("FAIL mul_latency: busy cycles=%0d Done=%b, required 4 1", busy_n, Done);
        end
        @(negedge clk);
        checks++;
        if (Result !== 8'hE1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL mul_ignore_start: Result=%h Done=%b, required e1 0", Result, Done);
        end
    endtask

    task automatic test_accumulate();
        issue(3'b000, 4'h1, 4'h2, 1'b0, 1'b1);
        issue(3'b000, 4'h2, 4'hF, 1'b1, 1'b1);
        issue(3'b000, 4'h2, 4'hF, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (Result !== 8'h07) begin
            errors++;
            $display("FAIL accumulate: got %h, required 07", Result);
        end
    endtask

    task automatic test_shl_hold();
        issue(3'b110, 4'h5, 4'h3, 1'b0, 1'b1);
        issue(3'b110, 4'h8, 4'hF, 1'b0, 1'b1);
        issue(3'b110, 4'h1, 4'h3, 1'b0, 1'b1);
        issue(3'b111, 4'hA, 4'h5, 1'b0, 1'b1);
        checks++;
        if (Done !== 1'b1 || Result !== 8'h06) begin
            errors++;
            $display("FAIL hold: Done=%b Result=%h, required 1 06", Done, Result);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [4] = '{3'b000, 3'b001, 3'b100, 3'b010};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive_op(ops[i], 4'(i * 3 + 1), 4'(i + 5), 1'b0, 1'b1);
            @(negedge clk);
            checks++;
            if (Done !== 1'b1) begin
                errors++;
                $display("FAIL b2b_done: op %0d Done=%b, required 1", i, Done);
            end
        end
        Start = 1'b0;
        @(negedge clk);
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_end: Done=%b, required 0", Done);
        end
    endtask

    task automatic test_reset_mid_mul();
        int waited;
        issue(3'b101, 4'h7, 4'h9, 1'b0, 1'b0);
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        checks++;
        if (Result !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mul: Result=%h Busy=%b Done=%b, required 00 0 0", Result, Busy, Done);
        end
        Reset = 1'b0;
        model_res = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (Done !== 1'b0 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet: Done=%b Busy=%b, required 0 0", Done, Busy);
            end
        end
        issue(3'b101, 4'h7, 4'h9, 1'b0, 1'b1);
        waited = 0;
        while (Done !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (Done !== 1'b1 || Result !== 8'h3F) begin
            errors++;
            $display("FAIL mul_after_reset: Done=%b Result=%h after %0d cycles, required 1 3f", Done, Result, waited);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_accumulate();
        test_shl_hold();
        test_back_to_back();
        test_reset_mid_mul();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done: %0d results outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu_reg.md
Name: seq_alu_reg

Overview:
- Parametrised, registered successor to the lab combinational ALU.
- Two WIDTH-bit operands; 2*WIDTH-bit result held in an output register.
- Adds a Start/Busy/Done handshake and a multi-cycle shift-add multiply.
- Adds an accumulate mode that feeds the registered result back as operand B.
- Sits between the switch/key inputs and the LEDR/HEX display logic.

Parameters:
- WIDTH, 4, operand width in bits (>=2); result width RW = 2*WIDTH.

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request: sample operands and opcode this edge.
- Opcode  input  3  operation select, see Behaviour.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B, used when UseReg=0.
- UseReg  input  1  1: operand B is Result[WIDTH-1:0] sampled at the Start edge.
- Busy  output  1  high while a multi-cycle op is in progress.
- Done  output  1  one-cycle pulse when Result has just been updated.
- Result  output  2*WIDTH  registered ALU result.

Behaviour:
- Reset (synchronous, dominant over all else): Result=0, Busy=0, Done=0, FSM=IDLE, internal multiplier state cleared.
- FSM states: IDLE, MUL.
- Start is accepted only in IDLE. Start in MUL is ignored and has no side effects.
- On acceptance, latch opA=A and opB=(UseReg ? Result[WIDTH-1:0] : B).
- Opcodes, single-cycle; result is zero-extended to RW unless stated:
  - 000 ADD: {carry, A+B}; carry lands in bit WIDTH, upper bits 0.
  - 001 SUB: (A-B) mod 2^WIDTH; bit WIDTH = borrow (1 when A<B); upper bits 0.
  - 010 NORNAND: {~(A|B), ~(A&B)}.
  - 011 ANYSET: upper WIDTH bits all 1 if (A|B)!=0; lower WIDTH bits 0.
  - 100 XORXNOR: {A^B, ~(A^B)}.
  - 110 SHL: zero-extended B shifted left by A; A>=RW gives 0.
  - 111 HOLD: Result unchanged; Done still pulses.
- Single-cycle timing: Start sampled at edge e0; Result valid and Done=1 after e0; Done=0 after e0+1 unless a new Start was accepted.
- Back-to-back single-cycle Starts are legal; Done stays high every cycle a result was written.
- 101 MUL (unsigned opA*opB, full RW bits):
  - Start at e0 -> MUL state, Busy=1 after e0.
  - One partial-product step per edge.
  - After e0+WIDTH: Result=product, Done=1, Busy=0, FSM=IDLE.
  - Result keeps its previous value during MUL; intermediate sums are internal only.
  - Start is sampled as a new request in the cycle after Busy falls (edge e0+WIDTH+1 at the earliest).
- Reset mid-MUL: abort; Result=0, no Done pulse.
- Done and Busy are never high in the same cycle.
- Result holds between operations.

Optional Feature:
- Macro: SEQ_ALU_FLAGS_EN.
- Defined: adds outputs Zero (1 bit) and Carry (1 bit), both registered and updated in the same edge as Result, both cleared by Reset.
  - Zero = (new Result==0).
  - Carry = ADD carry-out, SUB borrow, or for MUL (|product[RW-1:WIDTH]).
  - Carry = 0 for all other ops; HOLD keeps both flags unchanged.
- Not defined: ports absent; no flag logic.

Test Plan (WIDTH=4):
- Reset -> Result=8'h00, Busy=0, Done=0; hold Reset with Start=1, Opcode=ADD -> outputs stay 0.
- ADD, A=4'hF, B=4'h1, Start one cycle -> Result=8'h10 after next edge, Done high exactly one cycle; SUB A=2 B=3 -> Result=8'h1F.
- MUL, A=4'hF, B=4'hF -> Busy high 4 cycles, Result=8'hE1 with Done after edge 4; ADD Start at cycle 2 ignored, Result stays 8'hE1.
- Accumulate: Result=8'h03, ADD A=4'h2, UseReg=1, B=4'hF -> Result=8'h05; repeat -> 8'h07.
- SHL A=5, B=4'h3 -> 8'h60; A=8, B=4'hF -> 8'h00; HOLD -> Result unchanged, Done pulses.
- Reset asserted at cycle 2 of MUL A=7 B=9 -> Result=8'h00, Busy=0, no Done; a fresh MUL after Reset gives 8'h3F.
